// File: rtl/rchdc_pkg.sv
// Shared sizing, opcode and FSM encodings for the rchdc sequencer and datapath.
// Pure declarations: no logic, no latency, no flow control.
package rchdc_pkg;

  localparam int SMP_SIZE = 16;
  localparam int SET_SIZE = 4;
  localparam int PRED_SMP = 1;
  localparam int LVL_W    = 4;
  localparam int CLS_DW   = 4;
  localparam int DRAIN    = 2;
  localparam int RES_LAT  = 3;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int POS_W  = $clog2(SMP_SIZE);
  localparam int SIDX_W = $clog2(max2(SET_SIZE, PRED_SMP) + 1);
  localparam int DLY_W  = $clog2(max2(DRAIN, RES_LAT) + 1);

  typedef enum logic {OP_TRAIN = 1'b0, OP_PREDICT = 1'b1} op_e;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CLR  = 3'd1,
    FEED = 3'd2,
    DRN  = 3'd3,
    WAIT = 3'd4,
    RSP  = 3'd5
  } fsm_e;

  // Datapath mode value meaning "predict"; the datapath decodes the same constant.
  localparam logic PREDICT = 1'b1;

endpackage

// File: rtl/rchdc_seq_ctrl_if.sv
// Command, feature and response channels of the rchdc sequencer (valid/ready each).
// The slave side is the sequencer; the master side issues commands and features.
interface rchdc_seq_ctrl_if;

  logic                          cmd_valid;
  logic                          cmd_ready;
  logic                          cmd_op;
  logic [rchdc_pkg::CLS_DW-1:0]  cmd_label;

  logic                          feat_valid;
  logic                          feat_ready;
  logic [rchdc_pkg::LVL_W-1:0]   feat_level;

  logic                          rsp_valid;
  logic                          rsp_ready;
  logic                          rsp_op;
  logic [rchdc_pkg::CLS_DW-1:0]  rsp_class;

  modport master (
    output cmd_valid, cmd_op, cmd_label,
    input  cmd_ready,
    output feat_valid, feat_level,
    input  feat_ready,
    input  rsp_valid, rsp_op, rsp_class,
    output rsp_ready
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_label,
    output cmd_ready,
    input  feat_valid, feat_level,
    output feat_ready,
    output rsp_valid, rsp_op, rsp_class,
    input  rsp_ready
  );

endinterface

// File: rtl/rchdc_delay_cnt.sv
// Loadable down-counter with zero flag; load takes effect next cycle, then counts to 0 and holds.
// No flow control: the owner decides when a zero is meaningful.
module rchdc_delay_cnt #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/rchdc_seq_ctrl.sv
// Sequencer for the rchdc datapath: per op CLR, SET_SIZE/PRED_SMP samples of SMP_SIZE features, drain, result wait, response.
// Feature-to-smp_en latency 1 cycle; feature stream stalls freely, response holds until rsp_ready.
module rchdc_seq_ctrl
  import rchdc_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  rchdc_seq_ctrl_if.slave   bus,
  input  logic              abort,
  output logic [POS_W-1:0]  im_pos_addr,
  output logic [LVL_W-1:0]  im_val_addr,
  output logic              smp_en,
  output logic              smp_clr,
  output logic              set_clr,
  output logic              state,
  output logic [CLS_DW-1:0] label,
  input  logic [CLS_DW-1:0] predict,
  output logic              busy
);

  localparam logic [2:0] S_IDLE = IDLE;
  localparam logic [2:0] S_CLR  = CLR;
  localparam logic [2:0] S_FEED = FEED;
  localparam logic [2:0] S_DRN  = DRN;
  localparam logic [2:0] S_WAIT = WAIT;
  localparam logic [2:0] S_RSP  = RSP;
  // Abort clean-up cycle: clears both encoders before returning to IDLE.
  localparam logic [2:0] S_ABT  = 3'd6;

  logic [2:0]        fsm_q, fsm_d;
  logic              op_q;
  logic [CLS_DW-1:0] label_q;
  logic [CLS_DW-1:0] class_q;
  logic [SIDX_W-1:0] n_q, sidx_q;
  logic [POS_W-1:0]  fidx_q, pos_q;
  logic [LVL_W-1:0]  val_q;
  logic              smp_en_q;

  logic              dly_load, dly_zero;
  logic [DLY_W-1:0]  dly_val;
  logic              cmd_acc, feat_acc, abort_ok, fidx_last, more_smp;

  rchdc_delay_cnt #(.W(DLY_W)) u_dly (
    .clk      (clk),
    .rst      (rst),
    .load     (dly_load),
    .load_val (dly_val),
    .zero     (dly_zero)
  );

  assign abort_ok  = abort && (fsm_q == S_CLR || fsm_q == S_FEED ||
                               fsm_q == S_DRN || fsm_q == S_WAIT);
  assign cmd_acc   = bus.cmd_valid && bus.cmd_ready;
  assign feat_acc  = bus.feat_valid && bus.feat_ready;
  assign fidx_last = (fidx_q == POS_W'(SMP_SIZE - 1));
  assign more_smp  = (sidx_q < (n_q - SIDX_W'(1)));

  always_comb begin
    fsm_d    = fsm_q;
    dly_load = 1'b0;
    dly_val  = '0;
    case (fsm_q)
      S_IDLE: if (cmd_acc) fsm_d = S_CLR;
      S_CLR:  fsm_d = S_FEED;
      S_FEED: begin
        if (feat_acc && fidx_last) begin
          fsm_d    = S_DRN;
          dly_load = 1'b1;
          dly_val  = DLY_W'(DRAIN);
        end
      end
      S_DRN: begin
        // Counter reaching zero marks the sample-clear cycle.
        if (dly_zero) begin
          if (more_smp) begin
            fsm_d = S_FEED;
          end else begin
            fsm_d    = S_WAIT;
            dly_load = 1'b1;
            dly_val  = DLY_W'(RES_LAT - 1);
          end
        end
      end
      S_WAIT: if (dly_zero) fsm_d = S_RSP;
      S_RSP:  if (bus.rsp_ready) fsm_d = S_IDLE;
      default: fsm_d = S_IDLE;
    endcase
    if (abort_ok) fsm_d = S_ABT;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q    <= S_IDLE;
      op_q     <= 1'b0;
      label_q  <= '0;
      class_q  <= '0;
      n_q      <= '0;
      sidx_q   <= '0;
      fidx_q   <= '0;
      pos_q    <= '0;
      val_q    <= '0;
      smp_en_q <= 1'b0;
    end else begin
      fsm_q    <= fsm_d;
      smp_en_q <= feat_acc;
      if (cmd_acc) begin
        op_q    <= bus.cmd_op;
        label_q <= bus.cmd_label;
        n_q     <= (bus.cmd_op == OP_PREDICT) ? SIDX_W'(PRED_SMP) : SIDX_W'(SET_SIZE);
      end
      if (fsm_q == S_CLR) begin
        fidx_q <= '0;
        sidx_q <= '0;
      end
      if (feat_acc) begin
        fidx_q <= fidx_last ? '0 : fidx_q + POS_W'(1);
        pos_q  <= fidx_q;
        val_q  <= bus.feat_level;
      end
      if (fsm_q == S_DRN && fsm_d == S_FEED) sidx_q <= sidx_q + SIDX_W'(1);
      if (fsm_q == S_WAIT && fsm_d == S_RSP) class_q <= (op_q == PREDICT) ? predict : '0;
    end
  end

  assign bus.cmd_ready  = (fsm_q == S_IDLE);
  assign bus.feat_ready = (fsm_q == S_FEED) && !abort;
  assign bus.rsp_valid  = (fsm_q == S_RSP);
  assign bus.rsp_op     = (fsm_q == S_RSP) && op_q;
  assign bus.rsp_class  = class_q;

  assign im_pos_addr = pos_q;
  assign im_val_addr = val_q;
  assign smp_en      = smp_en_q;
  assign smp_clr     = (fsm_q == S_CLR) || (fsm_q == S_ABT) || (fsm_q == S_DRN && dly_zero);
  assign set_clr     = (fsm_q == S_CLR) || (fsm_q == S_ABT);
  assign busy        = (fsm_q != S_IDLE);
  assign state       = busy && op_q;
  assign label       = label_q;

endmodule

// File: tb/tb_rchdc_seq_ctrl.sv
// Directed-random bench: each op's expected cycle timeline is built from the op rules, then replayed against the DUT.
module tb_rchdc_seq_ctrl;
  import rchdc_pkg::*;

  localparam int MAXC = 1024;

  typedef struct packed {
    logic              cmd_rdy;
    logic              feat_rdy;
    logic              smp_en;
    logic              smp_clr;
    logic              set_clr;
    logic              st;
    logic              busy;
    logic              rsp_vld;
    logic              rsp_op;
    logic [CLS_DW-1:0] lbl;
    logic [CLS_DW-1:0] cls;
    logic [POS_W-1:0]  pos;
    logic [LVL_W-1:0]  val;
  } obs_t;

  typedef struct packed {
    logic              cv;
    logic              op;
    logic [CLS_DW-1:0] lbl;
    logic              fv;
    logic [LVL_W-1:0]  lvl;
    logic              ab;
    logic              rr;
  } stim_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              abort;
  logic [POS_W-1:0]  im_pos_addr;
  logic [LVL_W-1:0]  im_val_addr;
  logic              smp_en, smp_clr, set_clr, state, busy;
  logic [CLS_DW-1:0] label, predict;

  rchdc_seq_ctrl_if bus();

  rchdc_seq_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .abort       (abort),
    .im_pos_addr (im_pos_addr),
    .im_val_addr (im_val_addr),
    .smp_en      (smp_en),
    .smp_clr     (smp_clr),
    .set_clr     (set_clr),
    .state       (state),
    .label       (label),
    .predict     (predict),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  stim_t             stim [MAXC];
  obs_t              expv [MAXC];
  int                plen;
  logic [CLS_DW-1:0] held_lbl;
  logic              pend_op;
  logic [CLS_DW-1:0] pend_lbl;

  task automatic check(input string tag, input obs_t obs, input obs_t exp_v);
    compared++;
    assert (obs === exp_v) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp_v);
    compared++;
    assert (obs === exp_v) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  function automatic obs_t idle_vec(input logic [CLS_DW-1:0] lbl);
    obs_t v;
    v         = '0;
    v.cmd_rdy = 1'b1;
    v.lbl     = lbl;
    return v;
  endfunction

  function automatic obs_t sample_dut();
    obs_t o;
    o          = '0;
    o.cmd_rdy  = bus.cmd_ready;
    o.feat_rdy = bus.feat_ready;
    o.smp_en   = smp_en;
    o.smp_clr  = smp_clr;
    o.set_clr  = set_clr;
    o.st       = state;
    o.busy     = busy;
    o.rsp_vld  = bus.rsp_valid;
    o.rsp_op   = bus.rsp_op;
    o.lbl      = label;
    o.cls      = bus.rsp_valid ? bus.rsp_class : '0;
    o.pos      = smp_en ? im_pos_addr : '0;
    o.val      = smp_en ? im_val_addr : '0;
    return o;
  endfunction

  task automatic idle_inputs();
    bus.cmd_valid  = 1'b0;
    bus.feat_valid = 1'b0;
    bus.rsp_ready  = 1'b0;
    abort          = 1'b0;
  endtask

  // Timeline of one op, cycle 0 = command accept cycle.
  task automatic build(input logic op, input logic [CLS_DW-1:0] lbl, input logic nop,
                       input logic [CLS_DW-1:0] nlbl, input logic [CLS_DW-1:0] pv,
                       input int stall_pct, input int hold, input int ab_s, input int ab_k);
    int   c, t, r, run, n, k;
    obs_t busy_v;
    busy_v      = '0;
    busy_v.st   = op;
    busy_v.busy = 1'b1;
    busy_v.lbl  = lbl;
    for (int i = 0; i < MAXC; i++) begin
      stim[i]     = '0;
      stim[i].fv  = 1'($urandom_range(0, 1));
      stim[i].lvl = LVL_W'($urandom_range(0, 15));
      expv[i]     = busy_v;
    end
    stim[0].cv  = 1'b1;
    stim[0].op  = op;
    stim[0].lbl = lbl;
    expv[0]     = idle_vec(held_lbl);
    held_lbl    = lbl;
    expv[1].smp_clr = 1'b1;
    expv[1].set_clr = 1'b1;
    n = (op == PREDICT) ? PRED_SMP : SET_SIZE;
    c = 2;
    for (int s = 0; s < n; s++) begin
      k   = 0;
      run = 0;
      while (k < SMP_SIZE) begin
        expv[c].feat_rdy = 1'b1;
        if (s == ab_s && k == ab_k) begin
          stim[c].fv        = 1'b1;
          stim[c].ab        = 1'b1;
          expv[c].feat_rdy  = 1'b0;
          expv[c+1].smp_clr = 1'b1;
          expv[c+1].set_clr = 1'b1;
          plen = c + 2;
          return;
        end
        stim[c].fv = (run >= 3) || ($urandom_range(0, 99) >= stall_pct);
        if (stim[c].fv) begin
          expv[c+1].smp_en = 1'b1;
          expv[c+1].pos    = POS_W'(k);
          expv[c+1].val    = stim[c].lvl;
          k++;
          run = 0;
        end else begin
          run++;
        end
        c++;
      end
      t = c - 1;
      expv[t+1+DRAIN].smp_clr = 1'b1;
      c = t + DRAIN + 2;
    end
    r = (c - 1) + RES_LAT + 1;
    for (int h = 0; h <= hold; h++) begin
      expv[r+h].rsp_vld = 1'b1;
      expv[r+h].rsp_op  = op;
      expv[r+h].cls     = (op == PREDICT) ? pv : '0;
      stim[r+h].cv      = 1'b1;
      stim[r+h].op      = nop;
      stim[r+h].lbl     = nlbl;
      stim[r+h].ab      = (h == 0);
      stim[r+h].rr      = (h == hold);
    end
    plen = r + hold + 1;
  endtask

  task automatic run_plan(input string name, input int stop_at, input int exp_en);
    int en_cnt;
    en_cnt = 0;
    for (int c = 0; c < plen && c < stop_at; c++) begin
      bus.cmd_valid  = stim[c].cv;
      bus.cmd_op     = stim[c].op;
      bus.cmd_label  = stim[c].lbl;
      bus.feat_valid = stim[c].fv;
      bus.feat_level = stim[c].lvl;
      abort          = stim[c].ab;
      bus.rsp_ready  = stim[c].rr;
      #1;
      if (smp_en) en_cnt++;
      check($sformatf("%s cyc%0d", name, c), sample_dut(), expv[c]);
      @(negedge clk);
    end
    if (exp_en >= 0) check_int({name, " smp_en count"}, en_cnt, exp_en);
  endtask

  task automatic op_step(input string name, input logic nop, input logic [CLS_DW-1:0] nlbl,
                         input logic [CLS_DW-1:0] pv, input int stall_pct, input int hold,
                         input int ab_s, input int ab_k, input int stop_at);
    int n_exp;
    predict = pv;
    build(pend_op, pend_lbl, nop, nlbl, pv, stall_pct, hold, ab_s, ab_k);
    if (ab_s >= 0) n_exp = ab_s * SMP_SIZE + ab_k;
    else           n_exp = ((pend_op == PREDICT) ? PRED_SMP : SET_SIZE) * SMP_SIZE;
    if (stop_at < plen) n_exp = -1;
    run_plan(name, stop_at, n_exp);
    pend_op  = nop;
    pend_lbl = nlbl;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    idle_inputs();
    bus.cmd_op     = 1'b0;
    bus.cmd_label  = '0;
    bus.feat_level = '0;
    predict        = '0;
    held_lbl       = '0;
    pend_op        = 1'b0;
    pend_lbl       = 4'd3;

    @(negedge clk); #1;
    check("reset held", sample_dut(), idle_vec('0));
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset released", sample_dut(), idle_vec('0));
    @(negedge clk);

    op_step("train3_b2b",      1'b1, 4'd9,  4'd0,  0,  0, -1, -1, MAXC);
    op_step("predict5",        1'b0, 4'd12, 4'd5,  0,  2, -1, -1, MAXC);
    op_step("train_stall",     1'b1, 4'd1,  4'd0,  50, 1, -1, -1, MAXC);
    op_step("predict_stall",   1'b0, 4'd6,  4'd11, 50, 0, -1, -1, MAXC);
    op_step("train_abort",     1'b0, 4'd2,  4'd0,  30, 0,  2,  7, MAXC);
    op_step("train_after_abt", 1'b1, 4'd4,  4'd0,  0, 10, -1, -1, MAXC);
    op_step("predict_release", 1'b0, 4'd7,  4'($urandom_range(0, 15)), 20, 0, -1, -1, MAXC);

    for (int i = 0; i < 4; i++) begin
      op_step($sformatf("rand%0d", i), 1'($urandom_range(0, 1)),
              4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
              int'($urandom_range(0, 60)), int'($urandom_range(0, 3)), -1, -1, MAXC);
    end

    op_step("reset_mid_feed", 1'b0, 4'd8, 4'd3, 0, 0, -1, -1, 10);
    rst = 1'b1;
    idle_inputs();
    #1;
    check("rst mid-feed", sample_dut(), idle_vec('0));
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("after mid-feed rst", sample_dut(), idle_vec('0));
    held_lbl = '0;
    @(negedge clk);

    op_step("post_reset_train", 1'b0, 4'd0, 4'd0, 25, 1, -1, -1, MAXC);
    idle_inputs();
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
